// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with sized, sign/zero-extended loads.
// Define DMEM_ALIGN_CHECK_EN to reject accesses not aligned to their size.
module data_memory_sized #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Mem_Size,
    input  logic              Mem_Unsigned,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Read_Valid,
    output logic              Mem_Error
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);

    // Storage starts zeroed at time zero; reset deliberately leaves it alone.
    logic [7:0] mem [0:DEPTH-1] = '{default: 8'h00};

    logic [AW-1:0] addr_lo;
    logic [AW-1:0] baddr [NB];
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] rdata_q;
    logic valid_q;
    logic err_q;
    int nbytes;
    int nbits;
    logic size_ok;
    logic align_ok;
    logic legal;
    logic load_ok;
    logic store_ok;
    logic reject;
    logic fill;
    logic unused_addr_hi;

    // Upper address bits only select aliases of the same storage.
    assign addr_lo        = Mem_Addr[AW-1:0];
    assign unused_addr_hi = ^Mem_Addr[ADDR_W-1:AW];

    // Access length and legality of the requested size.
    always_comb begin
        nbytes = 1;
        unique case (Mem_Size)
            2'b00: nbytes = 1;
            2'b01: nbytes = 2;
            2'b10: nbytes = 4;
            2'b11: nbytes = 8;
        endcase
        size_ok = !(Mem_Size == 2'b11 && DATA_W == 32);
    end

    // Alignment policy chosen at build time.
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        align_ok = (addr_lo & AW'(nbytes - 1)) == '0;
`else
        align_ok = 1'b1;
`endif
    end

    // Request classification: store wins a read/write collision, load is dropped.
    always_comb begin
        legal    = size_ok && align_ok;
        store_ok = MemWrite && legal;
        load_ok  = MemRead && !MemWrite && legal;
        reject   = (MemRead && MemWrite)
                || ((MemRead || MemWrite) && !legal);
    end

    // Per-byte addresses wrap modulo DEPTH; gather the raw bytes.
    always_comb begin
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            baddr[k]         = addr_lo + AW'(k);
            raw[8*k +: 8]    = mem[baddr[k]];
        end
    end

    // Sign- or zero-extend the low N bytes to the full access width.
    always_comb begin
        nbits = 8 * nbytes;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        fill = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) begin
                fill = !Mem_Unsigned && raw[i];
            end
        end
        ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < nbits) ? raw[i] : fill;
        end
    end

    // Byte-lane store of the low N bytes; ignored while in reset.
    always_ff @(posedge clk) begin
        if (reset_n && store_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (k < nbytes) begin
                    mem[baddr[k]] <= WriteData[8*k +: 8];
                end
            end
        end
    end

    // Registered load result, valid and error pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= load_ok;
            err_q   <= reject;
            if (load_ok) begin
                rdata_q <= ext;
            end
        end
    end

    // A pulse pending when reset arrives is suppressed immediately.
    assign Read_Data  = rdata_q;
    assign Read_Valid = valid_q && reset_n;
    assign Mem_Error  = err_q && reset_n;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed self-checking bench for data_memory_sized (64-bit, 64-byte config).
// Misaligned-access expectations follow DMEM_ALIGN_CHECK_EN.
module tb_data_memory_sized;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] Mem_Addr;
    logic [63:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Mem_Size;
    logic        Mem_Unsigned;
    logic [63:0] Read_Data;
    logic        Read_Valid;
    logic        Mem_Error;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    data_memory_sized #(
        .DATA_W(64),
        .DEPTH (64),
        .ADDR_W(64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Mem_Addr    (Mem_Addr),
        .WriteData   (WriteData),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .Mem_Size    (Mem_Size),
        .Mem_Unsigned(Mem_Unsigned),
        .Read_Data   (Read_Data),
        .Read_Valid  (Read_Valid),
        .Mem_Error   (Mem_Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Mem_Size     = SZ_B;
        Mem_Unsigned = 1'b0;
        Mem_Addr     = '0;
        WriteData    = '0;
    endtask

    // Present one request for one edge, then go idle; outputs settle #1 later.
    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] addr,
                       input logic [63:0] data);
        MemRead      = rd;
        MemWrite     = wr;
        Mem_Size     = sz;
        Mem_Unsigned = uns;
        Mem_Addr     = addr;
        WriteData    = data;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_data", Read_Data, 64'h0);
        check("rst_valid", {63'h0, Read_Valid}, 64'h0);
        check("rst_err", {63'h0, Mem_Error}, 64'h0);

        req(1'b0, 1'b1, SZ_D, 1'b0, 64'd8, 64'h8877665544332211);
        check("st_valid", {63'h0, Read_Valid}, 64'h0);
        check("st_err", {63'h0, Mem_Error}, 64'h0);

        req(1'b1, 1'b0, SZ_D, 1'b0, 64'd8, 64'h0);
        check("ld_d8", Read_Data, 64'h8877665544332211);
        check("ld_d8_v", {63'h0, Read_Valid}, 64'h1);

        @(posedge clk);
        #1;
        check("hold_v", {63'h0, Read_Valid}, 64'h0);
        check("hold_d", Read_Data, 64'h8877665544332211);

        req(1'b1, 1'b0, SZ_B, 1'b0, 64'd15, 64'h0);
        check("lb15_s", Read_Data, 64'hFFFFFFFFFFFFFF88);
        check("lb15_s_v", {63'h0, Read_Valid}, 64'h1);
        req(1'b1, 1'b0, SZ_B, 1'b1, 64'd15, 64'h0);
        check("lb15_u", Read_Data, 64'h88);
        check("lb15_u_v", {63'h0, Read_Valid}, 64'h1);
        req(1'b1, 1'b0, SZ_H, 1'b0, 64'd8, 64'h0);
        check("lh8_s", Read_Data, 64'h2211);
        req(1'b1, 1'b0, SZ_H, 1'b0, 64'd14, 64'h0);
        check("lh14_s", Read_Data, 64'hFFFFFFFFFFFF8877);
        req(1'b1, 1'b0, SZ_W, 1'b0, 64'd12, 64'h0);
        check("lw12_s", Read_Data, 64'hFFFFFFFF88776655);
        req(1'b1, 1'b0, SZ_W, 1'b1, 64'd12, 64'h0);
        check("lw12_u", Read_Data, 64'h0000000088776655);

        req(1'b0, 1'b1, SZ_B, 1'b0, 64'd9, 64'h11223344556677AB);
        req(1'b1, 1'b0, SZ_D, 1'b0, 64'd8, 64'h0);
        check("sb9", Read_Data, 64'h887766554433AB11);

        req(1'b1, 1'b1, SZ_D, 1'b0, 64'd0, 64'd5);
        check("rw_err", {63'h0, Mem_Error}, 64'h1);
        check("rw_valid", {63'h0, Read_Valid}, 64'h0);
        check("rw_data", Read_Data, 64'h887766554433AB11);
        @(posedge clk);
        #1;
        check("err_pulse", {63'h0, Mem_Error}, 64'h0);
        req(1'b1, 1'b0, SZ_D, 1'b0, 64'd0, 64'h0);
        check("rw_ld0", Read_Data, 64'd5);
        check("rw_ld0_v", {63'h0, Read_Valid}, 64'h1);

        req(1'b1, 1'b0, SZ_D, 1'b0, 64'h1000000000000048, 64'h0);
        check("wrap_hi", Read_Data, 64'h887766554433AB11);

        req(1'b0, 1'b1, SZ_H, 1'b0, 64'd62, 64'hBEEF);
        req(1'b1, 1'b0, SZ_W, 1'b1, 64'd62, 64'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_err", {63'h0, Mem_Error}, 64'h1);
        check("mis_valid", {63'h0, Read_Valid}, 64'h0);
`else
        check("mis_data", Read_Data, 64'h000000000005BEEF);
        check("mis_valid", {63'h0, Read_Valid}, 64'h1);
        check("mis_err", {63'h0, Mem_Error}, 64'h0);
`endif

        req(1'b1, 1'b0, SZ_D, 1'b0, 64'd8, 64'h0);
        reset_n = 1'b0;
        #1;
        check("rst_kill_v", {63'h0, Read_Valid}, 64'h0);
        @(posedge clk);
        #1;
        check("rst_clr_d", Read_Data, 64'h0);
        req(1'b0, 1'b1, SZ_D, 1'b0, 64'd8, 64'h0);
        reset_n = 1'b1;
        check("rst_st_err", {63'h0, Mem_Error}, 64'h0);
        req(1'b1, 1'b0, SZ_D, 1'b0, 64'd8, 64'h0);
        check("keep_mem", Read_Data, 64'h887766554433AB11);
        check("keep_mem_v", {63'h0, Read_Valid}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
